// File: rtl/sm_vga_mem_arb.sv
// rtl/sm_vga_mem_arb.sv - SVGA memory port arbiter between CRT refresh fetch and CPU host access.
// Round-robin with CRT urgency, CPU anti-starvation and an ownership watchdog.
module sm_vga_mem_arb #(
  parameter int CPU_MAX_WAIT = 16,
  parameter int OWN_TIMEOUT  = 64
) (
  input  logic        mem_clk,
  input  logic        hreset,
  input  logic        sync_c_crt_line_end,
  input  logic        crt_cycle_req,
  input  logic        crt_urgent,
  input  logic        crt_svga_req,
  input  logic        crt_done,
  input  logic        cpu_req,
  input  logic        cpu_svga_req,
  input  logic        cpu_done,
  input  logic        svga_ack,
  output logic        crt_gnt,
  output logic        cpu_gnt,
  output logic        svga_req,
  output logic        crt_svga_ack,
  output logic        cpu_svga_ack,
  output logic        arb_timeout,
  output logic [15:0] probe
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CRT_OWN = 2'b01,
    CPU_OWN = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam logic       OWNER_CRT = 1'b0;
  localparam logic       OWNER_CPU = 1'b1;
  localparam logic [7:0] MAX_WAIT  = 8'(CPU_MAX_WAIT);
  localparam logic [7:0] TIMEOUT   = 8'(OWN_TIMEOUT);

  state_t     state;
  logic       last_owner;
  logic [7:0] cpu_wait_cnt;
  logic [7:0] own_cnt;

  logic starve;
  logic own_expired;
  logic pick_crt;
  logic pick_cpu;
  logic in_own;

  assign starve      = cpu_req && (cpu_wait_cnt >= MAX_WAIT);
  assign own_expired = own_cnt >= TIMEOUT;
  assign in_own      = (state == CRT_OWN) || (state == CPU_OWN);

  // IDLE decision: starvation first, then CRT urgency, then round robin on last_owner.
  always_comb begin
    pick_crt = 1'b0;
    pick_cpu = 1'b0;
    if (state == IDLE) begin
      if (starve) begin
        pick_cpu = 1'b1;
      end else if (crt_cycle_req && crt_urgent) begin
        pick_crt = 1'b1;
      end else if (crt_cycle_req && cpu_req) begin
        if (last_owner == OWNER_CPU) begin
          pick_crt = 1'b1;
        end else begin
          pick_cpu = 1'b1;
        end
      end else if (crt_cycle_req) begin
        pick_crt = 1'b1;
      end else if (cpu_req) begin
        pick_cpu = 1'b1;
      end
    end
  end

  // Done has priority over the watchdog so a completing owner never flags a timeout.
  always_ff @(posedge mem_clk or posedge hreset) begin
    if (hreset) begin
      state       <= IDLE;
      crt_gnt     <= 1'b0;
      cpu_gnt     <= 1'b0;
      arb_timeout <= 1'b0;
      last_owner  <= OWNER_CPU;
    end else begin
      arb_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_cpu) begin
            state      <= CPU_OWN;
            cpu_gnt    <= 1'b1;
            last_owner <= OWNER_CPU;
          end else if (pick_crt) begin
            state      <= CRT_OWN;
            crt_gnt    <= 1'b1;
            last_owner <= OWNER_CRT;
          end
        end
        CRT_OWN: begin
          if (crt_done || sync_c_crt_line_end) begin
            state   <= RELEASE;
            crt_gnt <= 1'b0;
          end else if (own_expired) begin
            state       <= RELEASE;
            crt_gnt     <= 1'b0;
            arb_timeout <= 1'b1;
          end
        end
        CPU_OWN: begin
          if (cpu_done) begin
            state   <= RELEASE;
            cpu_gnt <= 1'b0;
          end else if (own_expired) begin
            state       <= RELEASE;
            cpu_gnt     <= 1'b0;
            arb_timeout <= 1'b1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          crt_gnt <= 1'b0;
          cpu_gnt <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge mem_clk or posedge hreset) begin
    if (hreset) begin
      own_cnt <= 8'd0;
    end else if (pick_crt || pick_cpu || svga_ack) begin
      own_cnt <= 8'd0;
    end else if (in_own && (own_cnt != 8'hff)) begin
      own_cnt <= own_cnt + 8'd1;
    end
  end

  always_ff @(posedge mem_clk or posedge hreset) begin
    if (hreset) begin
      cpu_wait_cnt <= 8'd0;
    end else if (!cpu_req || cpu_gnt) begin
      cpu_wait_cnt <= 8'd0;
    end else if (cpu_wait_cnt != 8'hff) begin
      cpu_wait_cnt <= cpu_wait_cnt + 8'd1;
    end
  end

  assign svga_req     = (crt_gnt & crt_svga_req) | (cpu_gnt & cpu_svga_req);
  assign crt_svga_ack = svga_ack & crt_gnt;
  assign cpu_svga_ack = svga_ack & cpu_gnt;
  assign probe        = {state, last_owner, starve, cpu_wait_cnt, own_cnt[7:4]};

endmodule

// File: tb/tb_sm_vga_mem_arb.sv
// tb/tb_sm_vga_mem_arb.sv - Directed self-checking bench for sm_vga_mem_arb.
module tb_sm_vga_mem_arb;

  logic        mem_clk = 1'b0;
  logic        hreset;
  logic        sync_c_crt_line_end;
  logic        crt_cycle_req;
  logic        crt_urgent;
  logic        crt_svga_req;
  logic        crt_done;
  logic        cpu_req;
  logic        cpu_svga_req;
  logic        cpu_done;
  logic        svga_ack;
  logic        crt_gnt;
  logic        cpu_gnt;
  logic        svga_req;
  logic        crt_svga_ack;
  logic        cpu_svga_ack;
  logic        arb_timeout;
  logic [15:0] probe;

  int n_checks = 0;
  int n_fail   = 0;

  sm_vga_mem_arb #(.CPU_MAX_WAIT(16), .OWN_TIMEOUT(64)) dut (
    .mem_clk             (mem_clk),
    .hreset              (hreset),
    .sync_c_crt_line_end (sync_c_crt_line_end),
    .crt_cycle_req       (crt_cycle_req),
    .crt_urgent          (crt_urgent),
    .crt_svga_req        (crt_svga_req),
    .crt_done            (crt_done),
    .cpu_req             (cpu_req),
    .cpu_svga_req        (cpu_svga_req),
    .cpu_done            (cpu_done),
    .svga_ack            (svga_ack),
    .crt_gnt             (crt_gnt),
    .cpu_gnt             (cpu_gnt),
    .svga_req            (svga_req),
    .crt_svga_ack        (crt_svga_ack),
    .cpu_svga_ack        (cpu_svga_ack),
    .arb_timeout         (arb_timeout),
    .probe               (probe)
  );

  always #5 mem_clk = ~mem_clk;

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic bad;
    hreset = 1'b1;
    sync_c_crt_line_end = 1'b0;
    crt_cycle_req = 1'b0;
    crt_urgent = 1'b0;
    crt_svga_req = 1'b1;
    crt_done = 1'b0;
    cpu_req = 1'b0;
    cpu_svga_req = 1'b1;
    cpu_done = 1'b0;
    svga_ack = 1'b1;
    tick();
    tick();
    check("rst_gnts", {14'd0, crt_gnt, cpu_gnt}, 16'd0);
    check("rst_timeout", {15'd0, arb_timeout}, 16'd0);
    check("rst_svga_req", {15'd0, svga_req}, 16'd0);
    check("rst_acks", {14'd0, crt_svga_ack, cpu_svga_ack}, 16'd0);
    check("rst_probe", probe, 16'h2000);
    svga_ack = 1'b0;
    hreset = 1'b0;
    tick();

    // Contention round robin, CRT first after reset
    crt_cycle_req = 1'b1;
    cpu_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("rr_crt_gnt", {15'd0, crt_gnt}, (g % 2 == 0) ? 16'd1 : 16'd0);
      check("rr_cpu_gnt", {15'd0, cpu_gnt}, (g % 2 == 1) ? 16'd1 : 16'd0);
      check("rr_svga_req", {15'd0, svga_req}, 16'd1);
      repeat (4) tick();
      if (g % 2 == 0) crt_done = 1'b1;
      else cpu_done = 1'b1;
      tick();
      crt_done = 1'b0;
      cpu_done = 1'b0;
      check("rr_release", {14'd0, probe[15:14]}, 16'd3);
      tick();
    end
    crt_cycle_req = 1'b0;
    cpu_req = 1'b0;
    tick();

    // CRT only, ack routing, regrant timing
    crt_cycle_req = 1'b1;
    tick();
    check("crt_gnt_rise", {14'd0, crt_gnt, cpu_gnt}, 16'd2);
    check("crt_probe_hi", {13'd0, probe[15:13]}, 16'd2);
    svga_ack = 1'b1;
    #1;
    check("crt_ack_route", {14'd0, crt_svga_ack, cpu_svga_ack}, 16'd2);
    svga_ack = 1'b0;
    repeat (9) tick();
    crt_done = 1'b1;
    tick();
    crt_done = 1'b0;
    check("crt_gnt_fall", {15'd0, crt_gnt}, 16'd0);
    check("crt_req_masked", {15'd0, svga_req}, 16'd0);
    tick();
    check("crt_idle", {13'd0, crt_gnt, probe[15:14]}, 16'd0);
    tick();
    check("crt_regrant", {15'd0, crt_gnt}, 16'd1);
    crt_cycle_req = 1'b0;
    crt_done = 1'b1;
    tick();
    crt_done = 1'b0;
    tick();
    svga_ack = 1'b1;
    #1;
    check("idle_ack_drop", {14'd0, crt_svga_ack, cpu_svga_ack}, 16'd0);
    svga_ack = 1'b0;
    tick();

    // Urgent CRT versus starving CPU
    crt_urgent = 1'b1;
    crt_cycle_req = 1'b1;
    cpu_req = 1'b1;
    tick();
    check("urg_grant1", {14'd0, crt_gnt, cpu_gnt}, 16'd2);
    repeat (5) tick();
    crt_done = 1'b1;
    tick();
    crt_done = 1'b0;
    tick();
    check("urg_probe_w8", probe, 16'h0080);
    tick();
    check("urg_grant2", {14'd0, crt_gnt, cpu_gnt}, 16'd2);
    repeat (5) tick();
    crt_done = 1'b1;
    tick();
    crt_done = 1'b0;
    tick();
    check("starve_probe", probe, 16'h1100);
    tick();
    check("starve_cpu_gnt", {14'd0, crt_gnt, cpu_gnt}, 16'd1);
    crt_urgent = 1'b0;
    crt_cycle_req = 1'b0;

    // Watchdog release with no ack
    repeat (64) tick();
    check("wd_hold", {14'd0, cpu_gnt, arb_timeout}, 16'd2);
    check("wd_probe", probe, 16'ha004);
    tick();
    check("wd_fire", {14'd0, cpu_gnt, arb_timeout}, 16'd1);
    check("wd_state", {14'd0, probe[15:14]}, 16'd3);
    tick();
    check("wd_pulse_end", {15'd0, arb_timeout}, 16'd0);
    tick();
    check("wd_regrant", {15'd0, cpu_gnt}, 16'd1);

    // Periodic ack keeps the watchdog quiet
    bad = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      svga_ack = (i % 30 == 0);
      if (i == 30) begin
        #1;
        check("cpu_ack_route", {14'd0, crt_svga_ack, cpu_svga_ack}, 16'd1);
      end
      tick();
      if (arb_timeout || !cpu_gnt) bad = 1'b1;
    end
    svga_ack = 1'b0;
    check("ack_no_timeout", {15'd0, bad}, 16'd0);

    // Done coincident with expiry: done wins
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();
    tick();
    check("dt_regrant", {15'd0, cpu_gnt}, 16'd1);
    repeat (64) tick();
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    check("dt_done_wins", {14'd0, cpu_gnt, arb_timeout}, 16'd0);
    cpu_req = 1'b0;
    tick();

    // Line end aborts CRT but not CPU
    crt_cycle_req = 1'b1;
    tick();
    check("le_crt_gnt", {15'd0, crt_gnt}, 16'd1);
    tick();
    sync_c_crt_line_end = 1'b1;
    tick();
    sync_c_crt_line_end = 1'b0;
    check("le_crt_drop", {14'd0, crt_gnt, svga_req}, 16'd0);
    crt_cycle_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick();
    check("le_cpu_gnt", {15'd0, cpu_gnt}, 16'd1);
    sync_c_crt_line_end = 1'b1;
    tick();
    sync_c_crt_line_end = 1'b0;
    check("le_cpu_keep", {13'd0, cpu_gnt, svga_req, arb_timeout}, 16'd6);

    // Asynchronous reset during CPU ownership
    hreset = 1'b1;
    #1;
    check("arst_drop", {13'd0, crt_gnt, cpu_gnt, svga_req}, 16'd0);
    cpu_req = 1'b0;
    tick();
    hreset = 1'b0;
    tick();
    check("arst_idle", {13'd0, probe[15:14], cpu_gnt}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
